// File: rtl/bcd_time_counter_if.sv
// rtl/bcd_time_counter_if.sv - control inputs and BCD digit outputs of the time counter
interface bcd_time_counter_if;
    logic       run;
    logic       inc_min;
    logic       inc_hr;
    logic [1:0] h1;
    logic [3:0] h0;
    logic [2:0] m1;
    logic [3:0] m0;
    logic [2:0] s1;
    logic [3:0] s0;
    logic       sec_pulse;
    logic       disp_update;

    modport master (
        output run, inc_min, inc_hr,
        input  h1, h0, m1, m0, s1, s0, sec_pulse, disp_update
    );

    modport slave (
        input  run, inc_min, inc_hr,
        output h1, h0, m1, m0, s1, s0, sec_pulse, disp_update
    );
endinterface

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - 1 Hz prescaler with BCD seconds/minutes/hours and set buttons
module bcd_time_counter #(
    parameter int DIVIDER  = 12000000,
    parameter bit MODE_24H = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_time_counter_if.slave    tc
);

    localparam int             PW         = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIVIDER - 1);
    localparam logic [1:0]     H1_RST     = MODE_24H ? 2'd0 : 2'd1;
    localparam logic [3:0]     H0_RST     = MODE_24H ? 4'd0 : 4'd2;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    s1_q, s1_d;
    logic [3:0]    s0_q, s0_d;
    logic [2:0]    m1_q, m1_d;
    logic [3:0]    m0_q, m0_d;
    logic [1:0]    h1_q, h1_d;
    logic [3:0]    h0_q, h0_d;
    logic          sec_pulse_q, sec_pulse_d;
    logic          disp_update_q, disp_update_d;

    logic          tick;
    logic          take_tick;
    logic          sec_wrap;
    logic          min_wrap;
    logic [5:0]    hr_carried;

    // Sexagesimal BCD increment (00..59); the caller detects the 59 wrap itself.
    function automatic logic [6:0] inc_sexa(input logic [2:0] t, input logic [3:0] u);
        logic [2:0] nt;
        logic [3:0] nu;
        nt = t;
        nu = u;
        if (u == 4'd9) begin
            nu = 4'd0;
            nt = (t == 3'd5) ? 3'd0 : t + 3'd1;
        end else begin
            nu = u + 4'd1;
        end
        return {nt, nu};
    endfunction

    // Hour increment following the 24h (00..23) or 12h (01..12) wrap rule.
    function automatic logic [5:0] inc_hours(input logic [1:0] t, input logic [3:0] u);
        logic [1:0] nt;
        logic [3:0] nu;
        nt = t;
        nu = u;
        if (MODE_24H && t == 2'd2 && u == 4'd3) begin
            nt = 2'd0;
            nu = 4'd0;
        end else if (!MODE_24H && t == 2'd1 && u == 4'd2) begin
            nt = 2'd0;
            nu = 4'd1;
        end else if (u == 4'd9) begin
            nt = t + 2'd1;
            nu = 4'd0;
        end else begin
            nu = u + 4'd1;
        end
        return {nt, nu};
    endfunction

    // Tick qualification: a minute set in the same cycle discards the tick.
    always_comb begin
        tick      = tc.run && (presc_q == PRESC_LAST);
        take_tick = tick && !tc.inc_min;
    end

    // Prescaler: minute set realigns the second boundary, run=0 freezes it.
    always_comb begin
        presc_d = presc_q;
        if (tc.inc_min) begin
            presc_d = '0;
        end else if (tc.run) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // Seconds: cleared by a minute set, otherwise advanced by a tick.
    always_comb begin
        s1_d     = s1_q;
        s0_d     = s0_q;
        sec_wrap = take_tick && (s1_q == 3'd5) && (s0_q == 4'd9);
        if (tc.inc_min) begin
            s1_d = 3'd0;
            s0_d = 4'd0;
        end else if (take_tick) begin
            {s1_d, s0_d} = inc_sexa(s1_q, s0_q);
        end
    end

    // Minutes: the set button wraps 59->00 without touching hours.
    always_comb begin
        m1_d     = m1_q;
        m0_d     = m0_q;
        min_wrap = sec_wrap && (m1_q == 3'd5) && (m0_q == 4'd9);
        if (tc.inc_min || sec_wrap) begin
            {m1_d, m0_d} = inc_sexa(m1_q, m0_q);
        end
    end

    // Hours: carry first, then the hour button on top (can net +2 h).
    always_comb begin
        hr_carried = min_wrap ? inc_hours(h1_q, h0_q) : {h1_q, h0_q};
        {h1_d, h0_d} = tc.inc_hr ? inc_hours(hr_carried[5:4], hr_carried[3:0]) : hr_carried;
    end

    // Status pulses: seconds pulse only for real ticks, display pulse on any h/m change.
    always_comb begin
        sec_pulse_d   = take_tick;
        disp_update_d = ({h1_d, h0_d, m1_d, m0_d} != {h1_q, h0_q, m1_q, m0_q});
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q       <= '0;
            s1_q          <= 3'd0;
            s0_q          <= 4'd0;
            m1_q          <= 3'd0;
            m0_q          <= 4'd0;
            h1_q          <= H1_RST;
            h0_q          <= H0_RST;
            sec_pulse_q   <= 1'b0;
            disp_update_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            s1_q          <= s1_d;
            s0_q          <= s0_d;
            m1_q          <= m1_d;
            m0_q          <= m0_d;
            h1_q          <= h1_d;
            h0_q          <= h0_d;
            sec_pulse_q   <= sec_pulse_d;
            disp_update_q <= disp_update_d;
        end
    end

    assign tc.h1          = h1_q;
    assign tc.h0          = h0_q;
    assign tc.m1          = m1_q;
    assign tc.m0          = m0_q;
    assign tc.s1          = s1_q;
    assign tc.s0          = s0_q;
    assign tc.sec_pulse   = sec_pulse_q;
    assign tc.disp_update = disp_update_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - directed and random checks of both hour modes against an integer time model
module tb_bcd_time_counter;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bcd_time_counter_if if12 ();
    bcd_time_counter_if if24 ();

    bcd_time_counter #(.DIVIDER(DIV), .MODE_24H(1'b0)) dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .tc    (if12)
    );

    bcd_time_counter #(.DIVIDER(DIV), .MODE_24H(1'b1)) dut24 (
        .clk   (clk),
        .rst_n (rst_n),
        .tc    (if24)
    );

    int total = 0;
    int bad   = 0;

    // index 0 = 12h device, 1 = 24h device; time kept as plain integers
    int ps [2];
    int sc [2];
    int mn [2];
    int hr [2];
    bit sp [2];
    bit du [2];

    bit cur_r, cur_run, cur_im, cur_ih;

    function automatic int next_hr(input int m, input int h);
        return (m == 1) ? (h + 1) % 24 : (h % 12) + 1;
    endfunction

    task automatic model_edge();
        int oh, om;
        bit tk;
        for (int m = 0; m < 2; m++) begin
            if (!cur_r) begin
                ps[m] = 0; sc[m] = 0; mn[m] = 0;
                hr[m] = (m == 1) ? 0 : 12;
                sp[m] = 0; du[m] = 0;
            end else begin
                oh = hr[m];
                om = mn[m];
                sp[m] = 0;
                tk = cur_run && (ps[m] == DIV - 1);
                if (cur_im) begin
                    mn[m] = (mn[m] + 1) % 60;
                    sc[m] = 0;
                    ps[m] = 0;
                end else if (cur_run) begin
                    ps[m] = tk ? 0 : ps[m] + 1;
                    if (tk) begin
                        sp[m] = 1;
                        sc[m] = sc[m] + 1;
                        if (sc[m] == 60) begin
                            sc[m] = 0;
                            mn[m] = mn[m] + 1;
                            if (mn[m] == 60) begin
                                mn[m] = 0;
                                hr[m] = next_hr(m, hr[m]);
                            end
                        end
                    end
                end
                if (cur_ih) hr[m] = next_hr(m, hr[m]);
                du[m] = (mn[m] != om) || (hr[m] != oh);
            end
        end
    endtask

    function automatic logic [21:0] exp_vec(input int m);
        return {2'(hr[m] / 10), 4'(hr[m] % 10), 3'(mn[m] / 10), 4'(mn[m] % 10),
                3'(sc[m] / 10), 4'(sc[m] % 10), sp[m], du[m]};
    endfunction

    function automatic logic [21:0] obs12();
        return {if12.h1, if12.h0, if12.m1, if12.m0, if12.s1, if12.s0, if12.sec_pulse, if12.disp_update};
    endfunction

    function automatic logic [21:0] obs24();
        return {if24.h1, if24.h0, if24.m1, if24.m0, if24.s1, if24.s0, if24.sec_pulse, if24.disp_update};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input bit r, input bit run, input bit im, input bit ih);
        cur_r = r; cur_run = run; cur_im = im; cur_ih = ih;
        rst_n = r;
        if12.run = run; if12.inc_min = im; if12.inc_hr = ih;
        if24.run = run; if24.inc_min = im; if24.inc_hr = ih;
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, "_12h"}, 32'(obs12()), 32'(exp_vec(0)));
        chk({tag, "_24h"}, 32'(obs24()), 32'(exp_vec(1)));
    endtask

    // hh:mm:ss packed as BCD nibbles for directed constant checks
    function automatic logic [31:0] hms24();
        return {8'h00, 2'b00, if24.h1, if24.h0, 1'b0, if24.m1, if24.m0, 1'b0, if24.s1, if24.s0};
    endfunction

    function automatic logic [31:0] hms12();
        return {8'h00, 2'b00, if12.h1, if12.h0, 1'b0, if12.m1, if12.m0, 1'b0, if12.s1, if12.s0};
    endfunction

    initial begin
        int du_cnt, du_sp;

        // 1: reset values and first tick timing
        step("rst", 0, 0, 0, 0);
        step("rst", 0, 0, 0, 0);
        chk("rst_time24", hms24(), 32'h00_00_00);
        chk("rst_time12", hms12(), 32'h12_00_00);
        chk("rst_pulses", {30'd0, if24.sec_pulse, if24.disp_update}, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step("run", 1, 1, 0, 0);
            if (i == 3) chk("no_early_tick", 32'(if24.sec_pulse), 32'd0);
            if (i == 4) chk("first_tick_s0", {31'd0, if24.sec_pulse} | (32'(if24.s0) << 4), 32'h11);
        end

        // 2: sixty ticks roll seconds into minutes
        step("rst2", 0, 0, 0, 0);
        du_cnt = 0;
        du_sp  = 0;
        for (int i = 0; i < 60 * DIV; i++) begin
            step("min_carry", 1, 1, 0, 0);
            if (if24.disp_update) du_cnt++;
            if (if24.disp_update && if24.sec_pulse) du_sp++;
        end
        chk("min_carry_time", hms24(), 32'h00_01_00);
        chk("du_once", 32'(du_cnt), 32'd1);
        chk("du_with_tick", 32'(du_sp), 32'd1);

        // 3: preload 23:59 then full-day rollover
        step("rst3", 0, 0, 0, 0);
        for (int i = 0; i < 23; i++) step("set_hr", 1, 0, 0, 1);
        for (int i = 0; i < 59; i++) step("set_min", 1, 0, 1, 0);
        for (int i = 0; i < 59 * DIV; i++) step("to_2359", 1, 1, 0, 0);
        chk("at_235959", hms24(), 32'h23_59_59);
        for (int i = 0; i < DIV; i++) step("rollover", 1, 1, 0, 0);
        chk("rollover_time", hms24(), 32'h00_00_00);
        chk("rollover_pulses", {30'd0, if24.sec_pulse, if24.disp_update}, 32'd3);

        // 4: 12h hour wrap
        step("rst4", 0, 0, 0, 0);
        step("hr12_a", 1, 0, 0, 1);
        chk("hr12_one", hms12(), 32'h01_00_00);
        for (int i = 0; i < 11; i++) step("hr12_b", 1, 0, 0, 1);
        chk("hr12_twelve", hms12(), 32'h12_00_00);

        // 5: minute set mid-second, then set coincident with a tick
        step("rst5", 0, 0, 0, 0);
        for (int i = 0; i < 5 * DIV + 2; i++) step("mid_sec", 1, 1, 0, 0);
        step("set_mid", 1, 1, 1, 0);
        chk("set_mid_time", hms24(), 32'h00_01_00);
        for (int i = 1; i <= DIV; i++) begin
            step("realign", 1, 1, 0, 0);
            chk("realign_pulse", 32'(if24.sec_pulse), (i == DIV) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < DIV - 1; i++) step("pre_coinc", 1, 1, 0, 0);
        step("coinc", 1, 1, 1, 0);
        chk("coinc_pulse", 32'(if24.sec_pulse), 32'd0);
        chk("coinc_time", hms24(), 32'h00_02_00);

        // 6: freeze with hour set, then mid-count reset
        for (int i = 0; i < 2; i++) step("pre_freeze", 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step("freeze", 1, 0, 0, (i == 10) ? 1'b1 : 1'b0);
        chk("freeze_time", hms24(), 32'h01_02_00);
        for (int i = 0; i < 2; i++) step("thaw", 1, 1, 0, 0);
        chk("thaw_tick", 32'(if24.sec_pulse), 32'd1);
        step("count", 1, 1, 0, 0);
        step("rst6", 0, 1, 0, 0);
        chk("rst6_time24", hms24(), 32'h00_00_00);
        chk("rst6_time12", hms12(), 32'h12_00_00);

        // random soak
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
Timekeeping core of the binary clock. It divides the board clock down to a 1 Hz tick and keeps seconds, minutes and hours as BCD digits. It feeds the LED display stage with the h1/h0/m1/m0 digit columns, plus a one-cycle pulse whenever a displayed digit changes. It also accepts hour/minute set pulses from the (already debounced) user buttons.

Parameters:
DIVIDER, 12000000, board clock cycles per second tick; must be >= 2; benches use 4.
MODE_24H, 1, 1 = hours count 00..23; 0 = hours count 01..12.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
run  input  1  1 = timekeeping advances; 0 = prescaler and seconds frozen, set pulses still honoured
inc_min  input  1  single-cycle pulse from the minute button
inc_hr  input  1  single-cycle pulse from the hour button
h1  output  2  hours tens BCD (0..2)
h0  output  4  hours units BCD (0..9)
m1  output  3  minutes tens BCD (0..5)
m0  output  4  minutes units BCD (0..9)
s1  output  3  seconds tens BCD (0..5)
s0  output  4  seconds units BCD (0..9)
sec_pulse  output  1  high for the one cycle after the seconds change
disp_update  output  1  high for the one cycle after any of h1/h0/m1/m0 change

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low (rst_n sampled on the rising edge of clk) and has priority over everything else.
- Reset values: prescaler 0, all seconds/minutes digits 0, sec_pulse 0, disp_update 0. Hours are 00 when MODE_24H=1 and 12 (h1=1, h0=2) when MODE_24H=0.
- Reset asserted mid-count returns to these values on that edge. A pending tick is lost.
- Prescaler: counts 0..DIVIDER-1 while run=1 and holds while run=0.
  - A tick occurs in the cycle where the prescaler equals DIVIDER-1 and run=1.
  - On that edge the prescaler wraps to 0 and the seconds increment.
- Outputs are registered. On the edge ending a tick cycle:
  - the new digit values and sec_pulse=1 become visible together in the following cycle;
  - there is no extra latency.
- Carry chain:
  - s0 9->0 carries to s1; s1:s0 59->00 carries to minutes.
  - m0 9->0 carries to m1; m1:m0 59->00 carries to hours.
  - Hours, MODE_24H=1: 09->10, 19->20, 23->00.
  - Hours, MODE_24H=0: 09->10, 12->01 (no 00).
  - Full rollover: 23:59:59->00:00:00 (24h) and 12:59:59->01:00:00 (12h) happen on one edge.
- inc_min:
  - minutes +1, wrapping 59->00 with no carry into hours;
  - seconds and prescaler cleared to 0;
  - disp_update=1 next cycle.
- inc_hr:
  - hours +1 using the same wrap rules as the carry chain;
  - minutes, seconds and prescaler unchanged;
  - disp_update=1 next cycle.
- Simultaneous events:
  - inc_min with a tick: the set action wins, the tick is discarded and sec_pulse stays 0.
  - inc_min with inc_hr: both apply in the same edge, with the hour change independent of the minute wrap.
  - inc_hr with a tick: both apply. If the tick carries into hours in that same cycle, inc_hr is applied on top of the carried value (net +2 h).
- Set pulses held high for multiple cycles increment once per cycle; edge detection belongs upstream.
- sec_pulse: asserted only for ticks, never for set actions.
- disp_update: asserted for any change of minutes or hours, whether by carry or by set. It is not asserted for seconds-only changes.
- Illegal BCD values cannot arise; every digit register only ever holds legal values.

Test Plan:
1. DIVIDER=4, MODE_24H=1, rst_n=0 then 1, run=1 -> all digits 0. sec_pulse high every 4th cycle, first pulse 4 cycles after reset release, s0 reads 1.
2. From 00:00:00, run for 60 ticks -> s1:s0 59->00, m0=1. disp_update asserted exactly once, in the same cycle as sec_pulse on the 60th tick.
3. Preload via 23 inc_hr + 59 inc_min pulses, then 59 ticks -> time reads 23:59:59. The next tick reads 00:00:00 with sec_pulse=1 and disp_update=1.
4. MODE_24H=0 after reset -> 12:00:00. One inc_hr -> 01:00:00. Eleven more -> 12:00:00.
5. Mid-second (prescaler=2, s0=5), pulse inc_min -> seconds 00, m0 +1. The next tick occurs 4 cycles later, and inc_min coincident with a tick yields sec_pulse=0.
6. run=0 for 20 cycles -> digits and prescaler frozen, and inc_hr still increments hours. Then rst_n=0 for one cycle during a count -> all outputs return to their reset values the next cycle.
